// File: rtl/uart_tx_core_if.sv
// -----------------------------------------------------------------------------
// uart_tx_core_if
// Byte handshake between a producer and the UART transmitter core.
//   tx_valid_i : producer offers a byte
//   tx_data_i  : byte to send (DATA_W bits)
//   tx_ready_o : transmitter can accept a byte (high only while idle)
// Modports:
//   master : producer side (drives valid/data, observes ready)
//   slave  : transmitter side (observes valid/data, drives ready)
// -----------------------------------------------------------------------------
interface uart_tx_core_if #(
  parameter int DATA_W = 8
) ();
  logic              tx_valid_i;
  logic [DATA_W-1:0] tx_data_i;
  logic              tx_ready_o;

  modport master (
    output tx_valid_i,
    output tx_data_i,
    input  tx_ready_o
  );

  modport slave (
    input  tx_valid_i,
    input  tx_data_i,
    output tx_ready_o
  );
endinterface

// File: rtl/uart_tx_core.sv
// -----------------------------------------------------------------------------
// uart_tx_core
// Serial UART transmitter: start bit, DATA_W data bits LSB first, optional
// parity bit, STOP_BITS stop bits. Every bit lasts CLK_DIV clock cycles.
//
// State table
//   state  | meaning
//   IDLE   | line high, ready for a byte
//   START  | start bit (low)
//   DATA   | data bits, LSB first
//   PARITY | parity bit (only when PARITY_EN=1)
//   STOP   | stop bit(s) (high); done_o on the final cycle
//
// Ports
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous reset, active high
//   tx_if  : byte handshake (slave modport: valid/data in, ready out)
//   tx_o   : registered serial line, idle high
//   busy_o : frame in progress
//   done_o : one-cycle pulse in the last cycle of the final stop bit
// -----------------------------------------------------------------------------
module uart_tx_core #(
  parameter int DATA_W     = 8,
  parameter int CLK_DIV    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  uart_tx_core_if.slave  tx_if,
  output logic           tx_o,
  output logic           busy_o,
  output logic           done_o
);

  if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
    $error("uart_tx_core: DATA_W must be in 5..9");
  end
  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("uart_tx_core: CLK_DIV must be at least 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_core: STOP_BITS must be 1 or 2");
  end

  localparam int BAUD_W = $clog2(CLK_DIV);
  localparam int BIT_W  = $clog2(DATA_W + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic              PAR_USE   = (PARITY_EN != 0);
  localparam logic              PAR_INV   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                par_q, par_d;
  logic                tx_q, tx_d;
  logic                done_d;
  logic                baud_wrap;

  assign baud_wrap = (baud_q == BAUD_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  // Next-state logic. bit_q counts data bits in DATA and stop bits in STOP.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    done_d  = 1'b0;

    if (state_q != IDLE) begin
      baud_d = baud_wrap ? '0 : baud_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (tx_if.tx_valid_i) begin
          state_d = START;
          baud_d  = '0;
          bit_d   = '0;
          shift_d = tx_if.tx_data_i;
          // Same value as the XOR of the latched shift register.
          par_d   = (^tx_if.tx_data_i) ^ PAR_INV;
        end
      end
      START: begin
        if (baud_wrap) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (baud_wrap) begin
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = PAR_USE ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (baud_wrap) begin
          state_d = STOP;
          bit_d   = '0;
        end
      end
      STOP: begin
        if (baud_wrap) begin
          if (bit_q == STOP_LAST) begin
            state_d = IDLE;
            bit_d   = '0;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line value for the next cycle, derived from the next state so that tx_o
  // can come straight from a flop.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_d;
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  assign tx_o             = tx_q;
  assign tx_if.tx_ready_o = (state_q == IDLE);
  assign busy_o           = (state_q != IDLE);
  // Decoded from registers only; reset forces STOP-state terms low.
  assign done_o           = done_d;

endmodule
